// File: rtl/alu_shift_pkg.sv
// rtl/alu_shift_pkg.sv - shared types for the multi-cycle shift sequencer
package alu_shift_pkg;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift/rotate stage
module shift_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  shift_op_t        i_op,
  output logic [WIDTH-1:0] o_y,
  output logic             o_carry
);

  // Every right-moving op drops bit 0; only SLL drops the top bit.
  always_comb begin
    o_y     = i_a;
    o_carry = i_a[0];
    case (i_op)
      OP_SRL: o_y = {1'b0, i_a[WIDTH-1:1]};
      OP_SLL: begin
        o_y     = {i_a[WIDTH-2:0], 1'b0};
        o_carry = i_a[WIDTH-1];
      end
      OP_SRA: o_y = {i_a[WIDTH-1], i_a[WIDTH-1:1]};
      OP_ROR: o_y = {i_a[0], i_a[WIDTH-1:1]};
      default: o_y = i_a;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterates one shift step per clock until the amount is exhausted
module shift_sequencer
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [AMT_W-1:0] amt_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] y_o,
  output logic             carry_o,
  output logic             zero_o
);

  seq_state_t       r_state;
  shift_op_t        r_op;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;

  logic [WIDTH-1:0] w_step_y;
  logic             w_step_carry;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_a     (r_y),
    .i_op    (r_op),
    .o_y     (w_step_y),
    .o_carry (w_step_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_SRL;
      r_cnt   <= '0;
      r_y     <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_y     <= a_i;
            r_op    <= shift_op_t'(op_i);
            r_cnt   <= amt_i;
            r_carry <= 1'b0;
            r_state <= (amt_i == '0) ? ST_DONE : ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_y     <= w_step_y;
          r_carry <= w_step_carry;
          r_cnt   <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Status is decoded from state and registers only, so start_i never reaches an output.
  assign ready_o = (r_state != ST_SHIFT);
  assign busy_o  = (r_state == ST_SHIFT);
  assign done_o  = (r_state == ST_DONE);
  assign y_o     = r_y;
  assign carry_o = r_carry;
  assign zero_o  = (r_y == '0);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [1:0] op_i;
  logic [3:0] a_i;
  logic [2:0] amt_i;
  logic       ready_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] y_o;
  logic       carry_o;
  logic       zero_o;

  int tests;
  int fails;

  shift_sequencer #(.WIDTH(4), .AMT_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .amt_i   (amt_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .y_o     (y_o),
    .carry_o (carry_o),
    .zero_o  (zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for done; latency counts the accept edge as edge 1.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] a,
                        input logic [2:0] amt, input logic [3:0] exp_y,
                        input logic exp_c, input logic hold_start);
    int n;
    int busy_n;
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    amt_i   = amt;
    tick();
    if (hold_start) begin
      op_i  = 2'b01;
      a_i   = 4'b0101;
      amt_i = 3'd2;
    end else begin
      start_i = 1'b0;
      op_i    = 2'bxx;
      a_i     = 4'bxxxx;
      amt_i   = 3'bxxx;
    end
    n      = 1;
    busy_n = 0;
    while (done_o !== 1'b1 && n < 40) begin
      if (busy_o === 1'b1) busy_n++;
      check({tag, "_ready_low"}, {31'd0, ready_o}, 32'd0);
      tick();
      n++;
    end
    start_i = 1'b0;
    check({tag, "_done"},    {31'd0, done_o},  32'd1);
    check({tag, "_latency"}, n,                 amt + 1);
    check({tag, "_busy"},    busy_n,            amt);
    check({tag, "_y"},       {28'd0, y_o},     {28'd0, exp_y});
    check({tag, "_carry"},   {31'd0, carry_o}, {31'd0, exp_c});
    check({tag, "_zero"},    {31'd0, zero_o},  {31'd0, (exp_y == 4'd0)});
  endtask

  // One idle cycle: done must already have dropped and the result must hold.
  task automatic idle_check(input string tag, input logic [3:0] exp_y);
    tick();
    check({tag, "_pulse"}, {31'd0, done_o}, 32'd0);
    check({tag, "_hold"},  {28'd0, y_o},    {28'd0, exp_y});
    check({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
  endtask

  initial begin
    logic saw_done;
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    start_i = 1'b0;
    op_i    = 2'b00;
    a_i     = 4'd0;
    amt_i   = 3'd0;
    tick();
    tick();
    check("rst_y",     {28'd0, y_o},     32'd0);
    check("rst_carry", {31'd0, carry_o}, 32'd0);
    check("rst_done",  {31'd0, done_o},  32'd0);
    check("rst_busy",  {31'd0, busy_o},  32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_zero",  {31'd0, zero_o},  32'd1);
    rst_n = 1'b1;
    tick();

    run_op("srl1",  2'b00, 4'b1000, 3'd1, 4'b0100, 1'b0, 1'b0); idle_check("srl1", 4'b0100);
    run_op("srl2",  2'b00, 4'b1111, 3'd2, 4'b0011, 1'b1, 1'b0); idle_check("srl2", 4'b0011);
    run_op("sll2",  2'b01, 4'b0011, 3'd2, 4'b1100, 1'b0, 1'b0); idle_check("sll2", 4'b1100);
    run_op("sra3",  2'b10, 4'b1000, 3'd3, 4'b1111, 1'b0, 1'b0); idle_check("sra3", 4'b1111);
    run_op("sra7",  2'b10, 4'b0110, 3'd7, 4'b0000, 1'b0, 1'b0); idle_check("sra7", 4'b0000);
    run_op("ror1",  2'b11, 4'b1001, 3'd1, 4'b1100, 1'b1, 1'b0); idle_check("ror1", 4'b1100);
    run_op("ror5",  2'b11, 4'b1001, 3'd5, 4'b1100, 1'b1, 1'b0); idle_check("ror5", 4'b1100);
    run_op("amt0",  2'b00, 4'b0000, 3'd0, 4'b0000, 1'b0, 1'b0); idle_check("amt0", 4'b0000);
    run_op("srlz",  2'b00, 4'b0001, 3'd1, 4'b0000, 1'b1, 1'b0); idle_check("srlz", 4'b0000);
    run_op("hold",  2'b00, 4'b1111, 3'd3, 4'b0001, 1'b1, 1'b1); idle_check("hold", 4'b0001);

    // Second request presented during the DONE cycle of the first.
    run_op("b2b_a", 2'b01, 4'b0001, 3'd2, 4'b0100, 1'b0, 1'b0);
    run_op("b2b_b", 2'b11, 4'b0110, 3'd3, 4'b1100, 1'b1, 1'b0);
    idle_check("b2b", 4'b1100);

    // Abort mid-operation with reset.
    start_i = 1'b1;
    op_i    = 2'b01;
    a_i     = 4'b0001;
    amt_i   = 3'd3;
    tick();
    start_i = 1'b0;
    check("abort_busy", {31'd0, busy_o}, 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ready", {31'd0, ready_o}, 32'd1);
    check("abort_busy0", {31'd0, busy_o},  32'd0);
    check("abort_y",     {28'd0, y_o},     32'd0);
    check("abort_carry", {31'd0, carry_o}, 32'd0);
    check("abort_zero",  {31'd0, zero_o},  32'd1);
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done_o !== 1'b0) saw_done = 1'b1;
      tick();
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    check("abort_idle",    {31'd0, ready_o},  32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
